// File: rtl/sc_token_pkg.sv
// -----------------------------------------------------------------------------
// sc_token_pkg
// Shared definitions for the synchronous-side token-ring transmitter:
// handshake state encoding, token counter width and default geometry.
// No ports (package).
// -----------------------------------------------------------------------------
package sc_token_pkg;

   localparam int unsigned STATE_W     = 2;
   localparam int unsigned TOKEN_CNT_W = 16;
   localparam int unsigned DEF_DW      = 8;
   localparam int unsigned DEF_DEPTH   = 4;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      REQ_HI = 2'd2,
      REQ_LO = 2'd3
   } state_t;

endpackage

// File: rtl/sc_token_sync.sv
// -----------------------------------------------------------------------------
// sc_token_sync
// Level synchronizer (flop chain) for the asynchronous ring ACK.
// Ports:
//   i_clk  system clock
//   i_rst  synchronous active-high reset, clears every stage
//   i_d    asynchronous input
//   o_q    synchronized output (i_d delayed by STAGES flops)
// -----------------------------------------------------------------------------
module sc_token_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_sync <= '0;
      else       r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/sc_token_tx.sv
// -----------------------------------------------------------------------------
// sc_token_tx
// Synchronous-side transmitter for the self-timed token ring. Tokens from
// clocked logic are buffered in a small FIFO and launched one at a time with
// a 4-phase return-to-zero REQ/ACK handshake; DATA_OUT is held stable from
// one cycle before REQ rises until ACK has returned low.
// Ports:
//   CLK        system clock
//   RST        synchronous active-high reset
//   IN_VALID   upstream offers a token
//   IN_READY   FIFO can accept a token (registered)
//   IN_DATA    token payload
//   REQ        ring request (flop output)
//   ACK        ring acknowledge (asynchronous)
//   DATA_OUT   bundled data (flop output)
//   TOKEN_CNT  tokens fully delivered, wraps
//   BUSY       FIFO non-empty or handshake in progress
//   ERR        (SC_TOKEN_TX_TIMEOUT_EN only) sticky handshake timeout
// Build option: define SC_TOKEN_TX_TIMEOUT_EN to add the TIMEOUT parameter,
// the ERR port and the handshake watchdog.
// -----------------------------------------------------------------------------
module sc_token_tx
   import sc_token_pkg::*;
#(
   parameter int unsigned DW          = DEF_DW,
   parameter int unsigned DEPTH       = DEF_DEPTH,
   parameter int unsigned SYNC_STAGES = 2
`ifdef SC_TOKEN_TX_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT     = 1024
`endif
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   input  logic [DW-1:0]          IN_DATA,
   output logic                   REQ,
   input  logic                   ACK,
   output logic [DW-1:0]          DATA_OUT,
   output logic [TOKEN_CNT_W-1:0] TOKEN_CNT,
   output logic                   BUSY
`ifdef SC_TOKEN_TX_TIMEOUT_EN
   ,
   output logic                   ERR
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DW-1:0]          r_mem [DEPTH];
   logic [AW-1:0]          r_wr_ptr;
   logic [AW-1:0]          r_rd_ptr;
   logic [AW:0]            r_count;
   logic                   r_in_ready;
   logic                   r_req;
   logic [DW-1:0]          r_data;
   logic [TOKEN_CNT_W-1:0] r_token_cnt;
   state_t                 r_state;

   state_t                 w_state_nxt;
   logic                   w_ack_s;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_deliver;
   logic [AW:0]            w_count_nxt;

   sc_token_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .i_clk (CLK),
      .i_rst (RST),
      .i_d   (ACK),
      .o_q   (w_ack_s)
   );

   assign w_push      = IN_VALID && r_in_ready;
   assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

`ifdef SC_TOKEN_TX_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT) + 1;

   logic [TW-1:0] r_tmo;
   logic          r_err;
   logic          w_in_hs;
   logic          w_timeout;

   assign w_in_hs   = (r_state == REQ_HI) || (r_state == REQ_LO);
   assign w_timeout = w_in_hs && (r_tmo == TW'(TIMEOUT - 1));

   // Watchdog restarts on every handshake state change.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_tmo <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_timeout) r_err <= 1'b1;
         if (w_in_hs && (w_state_nxt == r_state)) r_tmo <= r_tmo + 1'b1;
         else                                     r_tmo <= '0;
      end
   end

   assign ERR = r_err;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_deliver   = 1'b0;
      case (r_state)
         // A pending ACK from the ring stalls the launch: REQ never rises
         // while the synchronized ACK is still high.
         IDLE: begin
            if ((r_count != '0) && !w_ack_s) begin
               w_pop       = 1'b1;
               w_state_nxt = SETUP;
            end
         end
         SETUP:   if (!w_ack_s) w_state_nxt = REQ_HI;
         REQ_HI:  if (w_ack_s)  w_state_nxt = REQ_LO;
         REQ_LO: begin
            if (!w_ack_s) begin
               w_deliver   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
`ifdef SC_TOKEN_TX_TIMEOUT_EN
      if (w_timeout) begin
         w_deliver   = 1'b0;
         w_state_nxt = IDLE;
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wr_ptr] <= IN_DATA;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_in_ready  <= 1'b0;
         r_req       <= 1'b0;
         r_data      <= '0;
         r_token_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         // Ready is the registered form of !full, so IN_VALID never reaches
         // IN_READY combinationally.
         r_in_ready <= (w_count_nxt != (AW+1)'(DEPTH));
         // REQ mirrors the next state so it comes straight from a flop.
         r_req      <= (w_state_nxt == REQ_HI);
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_data   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_deliver) r_token_cnt <= r_token_cnt + 1'b1;
      end
   end

   assign IN_READY  = r_in_ready;
   assign REQ       = r_req;
   assign DATA_OUT  = r_data;
   assign TOKEN_CNT = r_token_cnt;
   assign BUSY      = (r_count != '0) || (r_state != IDLE);

endmodule

// File: tb/tb_sc_token_tx.sv
// -----------------------------------------------------------------------------
// tb_sc_token_tx
// Self-checking bench for sc_token_tx: pushed tokens go to an expected queue,
// popped and compared when REQ rises; a ring model answers the handshake.
// -----------------------------------------------------------------------------
module tb_sc_token_tx;

   localparam int unsigned SYNC = 2;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic [7:0]  IN_DATA = '0;
   logic        REQ;
   logic        ACK = 1'b0;
   logic [7:0]  DATA_OUT;
   logic [15:0] TOKEN_CNT;
   logic        BUSY;
`ifdef SC_TOKEN_TX_TIMEOUT_EN
   logic        ERR;
`endif

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [7:0]  exp_q [$];
   logic [15:0] exp_cnt = '0;
   logic [7:0]  held = '0;
   logic        prev_req = 1'b0;
   logic        ring_on = 1'b0;
   int          ring_dly = 3;
   int          ring_cnt = 0;

   sc_token_tx #(
      .DW          (8),
      .DEPTH       (4),
      .SYNC_STAGES (SYNC)
`ifdef SC_TOKEN_TX_TIMEOUT_EN
      ,
      .TIMEOUT     (16)
`endif
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_DATA   (IN_DATA),
      .REQ       (REQ),
      .ACK       (ACK),
      .DATA_OUT  (DATA_OUT),
      .TOKEN_CNT (TOKEN_CNT),
      .BUSY      (BUSY)
`ifdef SC_TOKEN_TX_TIMEOUT_EN
      ,
      .ERR       (ERR)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every REQ rise must carry the oldest outstanding token.
   initial forever begin
      @(negedge CLK);
      if (REQ && !prev_req) begin
         check("req_has_token", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("data_order", 32'(DATA_OUT), 32'(exp_q.pop_front()));
         held = DATA_OUT;
      end
      prev_req = REQ;
   end

   // Ring model: raise ACK ring_dly cycles after REQ, drop it ring_dly
   // cycles after REQ falls.
   initial forever begin
      @(negedge CLK);
      if (ring_on) begin
         if (REQ && !ACK) begin
            if (ring_cnt >= ring_dly - 1) begin ACK = 1'b1; ring_cnt = 0; end
            else ring_cnt++;
         end else if (!REQ && ACK) begin
            if (ring_cnt >= ring_dly - 1) begin
               check("data_hold", 32'(DATA_OUT), 32'(held));
               ACK = 1'b0;
               ring_cnt = 0;
               exp_cnt++;
            end else ring_cnt++;
         end else ring_cnt = 0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      @(negedge CLK);
      RST = 1'b1;
      IN_VALID = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      exp_q.delete();
      exp_cnt = '0;
      ring_cnt = 0;
      repeat (3) @(negedge CLK);
   endtask

   task automatic push(input logic [7:0] d);
      logic acc;
      acc = 1'b0;
      @(negedge CLK);
      IN_VALID = 1'b1;
      IN_DATA  = d;
      for (int t = 0; t < 300 && !acc; t++) begin
         acc = IN_READY;
         if (acc) exp_q.push_back(d);
         @(posedge CLK);
         if (!acc) @(negedge CLK);
      end
      if (!acc) check("push_accept", 32'(IN_READY), 32'd1);
      #1 IN_VALID = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge CLK);
      while ((BUSY || REQ || ACK) && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 2000) check("idle_timeout", 32'(BUSY), 32'd0);
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      int   n;
      logic seen;

      // Reset values while RST is held
      repeat (2) @(negedge CLK);
      check("rst_req",      32'(REQ),       32'd0);
      check("rst_data",     32'(DATA_OUT),  32'd0);
      check("rst_cnt",      32'(TOKEN_CNT), 32'd0);
      check("rst_busy",     32'(BUSY),      32'd0);
      check("rst_in_ready", 32'(IN_READY),  32'd0);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      check("ready_after_rst", 32'(IN_READY), 32'd1);

      // Single token: push-to-REQ latency of 3 edges
      ring_dly = 3;
      ring_on  = 1'b1;
      IN_VALID = 1'b1;
      IN_DATA  = 8'hA5;
      exp_q.push_back(8'hA5);
      @(posedge CLK);
      #1 IN_VALID = 1'b0;
      n = 1;
      while (!REQ && n < 20) begin
         @(posedge CLK);
         #1 n++;
      end
      check("req_latency", 32'(n), 32'd3);
      check("single_data", 32'(DATA_OUT), 32'h0000_00A5);
      wait_idle();
      check("single_cnt",  32'(TOKEN_CNT), 32'(exp_cnt));
      check("single_busy", 32'(BUSY), 32'd0);

      // Burst fill with a slow ring
      ring_dly = 8;
      apply_reset();
      for (int i = 1; i <= 4; i++) push(8'(i));
      check("burst_ready_open", 32'(IN_READY), 32'd1);
      push(8'h05);
      check("burst_ready_full", 32'(IN_READY), 32'd0);
      check("burst_busy", 32'(BUSY), 32'd1);
      push(8'h06);
      wait_idle();
      check("burst_cnt", 32'(TOKEN_CNT), 32'(exp_cnt));
      check("burst_cnt6", 32'(exp_cnt), 32'd6);

      // Stuck ACK across reset release
      ring_on = 1'b0;
      ACK = 1'b1;
      apply_reset();
      push(8'h33);
      seen = 1'b0;
      repeat (10) begin
         @(negedge CLK);
         seen = seen | REQ;
      end
      check("stuck_req_low", 32'(seen), 32'd0);
      ACK = 1'b0;
      n = 0;
      while (!REQ && n < 20) begin
         @(posedge CLK);
         #1 n++;
      end
      check("stuck_req_rise", 32'(REQ && (n <= SYNC + 2)), 32'd1);
      ring_dly = 3;
      ring_on  = 1'b1;
      wait_idle();
      check("stuck_cnt", 32'(TOKEN_CNT), 32'd1);

      // Reset in the middle of a handshake with two tokens queued
      ring_on = 1'b0;
      apply_reset();
      push(8'h41);
      push(8'h42);
      push(8'h43);
      check("midrst_req_pre", 32'(REQ), 32'd1);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      exp_q.delete();
      exp_cnt = '0;
      check("midrst_req",  32'(REQ),       32'd0);
      check("midrst_cnt",  32'(TOKEN_CNT), 32'd0);
      check("midrst_busy", 32'(BUSY),      32'd0);
      seen = 1'b0;
      repeat (6) begin
         @(negedge CLK);
         seen = seen | REQ | BUSY;
      end
      check("midrst_fifo_empty", 32'(seen), 32'd0);

      // Token counter wrap
      ring_dly = 2;
      ring_on  = 1'b1;
      apply_reset();
      @(negedge CLK);
      force dut.r_token_cnt = 16'hFFFF;
      @(posedge CLK);
      #1 release dut.r_token_cnt;
      exp_cnt = 16'hFFFF;
      check("wrap_preset", 32'(TOKEN_CNT), 32'(exp_cnt));
      push(8'h5A);
      wait_idle();
      check("wrap_cnt", 32'(TOKEN_CNT), 32'(exp_cnt));

`ifdef SC_TOKEN_TX_TIMEOUT_EN
      // Handshake timeout: ring never answers the first token
      ring_on = 1'b0;
      apply_reset();
      push(8'h11);
      push(8'h22);
      n = 0;
      while (!REQ && n < 20) begin
         @(posedge CLK);
         #1 n++;
      end
      check("tmo_req_rise", 32'(REQ), 32'd1);
      repeat (15) @(posedge CLK);
      #1 check("tmo_req_hold", 32'(REQ), 32'd1);
      check("tmo_err_pre", 32'(ERR), 32'd0);
      @(posedge CLK);
      #1 check("tmo_req_drop", 32'(REQ), 32'd0);
      check("tmo_err", 32'(ERR), 32'd1);
      ring_dly = 3;
      ring_on  = 1'b1;
      wait_idle();
      check("tmo_next_cnt", 32'(TOKEN_CNT), 32'(exp_cnt));
      check("tmo_err_sticky", 32'(ERR), 32'd1);
`endif

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
